// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Orders the board-level reset release for the Ethernet datapath.
//            1. Waits for a stable PLL lock.
//            2. Pulses the external PHY hardware reset.
//            3. Waits for the PHY to settle.
//            4. Releases the MAC reset, then the application reset.
//            The sequence re-runs on PLL lock loss or on a soft-reset request.
// Ports    : clk          in  1  system clock
//            sreset       in  1  synchronous active-high reset
//            pll_locked   in  1  PLL lock indicator (already synchronised)
//            soft_rst     in  1  single-cycle soft-reset request
//            phy_rst_n    out 1  external PHY hardware reset, active low
//            mac_sreset   out 1  MAC synchronous reset, active high
//            app_sreset   out 1  application synchronous reset, active high
//            ready        out 1  high only while the sequence is complete
//            state        out 3  current state encoding (debug/LED)
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int LOCK_CYCLES     = 16,
  parameter int PHY_RST_CYCLES  = 1000,
  parameter int PHY_WAIT_CYCLES = 10000,
  parameter int MAC_WAIT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       sreset,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       phy_rst_n,
  output logic       mac_sreset,
  output logic       app_sreset,
  output logic       ready,
  output logic [2:0] state
);

  // Shared counter is sized from the largest interval it must time.
  localparam int c_MAX_AB   = (LOCK_CYCLES > PHY_RST_CYCLES) ? LOCK_CYCLES : PHY_RST_CYCLES;
  localparam int c_MAX_CD   = (PHY_WAIT_CYCLES > MAC_WAIT_CYCLES) ? PHY_WAIT_CYCLES : MAC_WAIT_CYCLES;
  localparam int c_MAX_CYC  = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
  localparam int c_CTR_W    = $clog2(c_MAX_CYC) + 1;

  // Terminal counts: a state of length N exits when the counter reads N-1.
  localparam logic [c_CTR_W-1:0] c_LOCK_LAST     = c_CTR_W'(LOCK_CYCLES - 1);
  localparam logic [c_CTR_W-1:0] c_PHY_RST_LAST  = c_CTR_W'(PHY_RST_CYCLES - 1);
  localparam logic [c_CTR_W-1:0] c_PHY_WAIT_LAST = c_CTR_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [c_CTR_W-1:0] c_MAC_WAIT_LAST = c_CTR_W'(MAC_WAIT_CYCLES - 1);
  localparam logic [c_CTR_W-1:0] c_CTR_MAX       = {c_CTR_W{1'b1}};

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_PHY_RST   = 3'd1,
    ST_PHY_WAIT  = 3'd2,
    ST_MAC_WAIT  = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_CTR_W-1:0]   r_ctr;
  logic [c_CTR_W-1:0]   w_ctr_next;
  logic                 w_ctr_clr;
  logic                 w_ctr_inc;

  logic                 r_phy_rst_n;
  logic                 r_mac_sreset;
  logic                 r_app_sreset;
  logic                 r_ready;
  logic                 w_phy_rst_n_next;
  logic                 w_mac_sreset_next;
  logic                 w_app_sreset_next;
  logic                 w_ready_next;

  // --------------------------------------------------------------------------
  // State and output registers. Outputs are decoded from the next state and
  // registered alongside it, so they always match the visible state while
  // leaving no combinational path from any input to any output.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state      <= ST_WAIT_LOCK;
      r_ctr        <= '0;
      r_phy_rst_n  <= 1'b0;
      r_mac_sreset <= 1'b1;
      r_app_sreset <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_ctr        <= w_ctr_next;
      r_phy_rst_n  <= w_phy_rst_n_next;
      r_mac_sreset <= w_mac_sreset_next;
      r_app_sreset <= w_app_sreset_next;
      r_ready      <= w_ready_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Within the sequencing states the abort priority is:
  // lock loss (back to WAIT_LOCK), then soft reset (restart the PHY pulse),
  // then the normal timed transition.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_ctr_clr    = 1'b0;
    w_ctr_inc    = 1'b0;

    case (r_state)
      ST_WAIT_LOCK: begin
        // Lock filter: any unlocked cycle restarts the count. soft_rst has
        // no effect here.
        if (!pll_locked) begin
          w_ctr_clr = 1'b1;
        end else if (r_ctr == c_LOCK_LAST) begin
          w_next_state = ST_PHY_RST;
          w_ctr_clr    = 1'b1;
        end else begin
          w_ctr_inc = 1'b1;
        end
      end

      ST_PHY_RST: begin
        if (!pll_locked) begin
          w_next_state = ST_WAIT_LOCK;
          w_ctr_clr    = 1'b1;
        end else if (soft_rst) begin
          w_next_state = ST_PHY_RST;
          w_ctr_clr    = 1'b1;
        end else if (r_ctr == c_PHY_RST_LAST) begin
          w_next_state = ST_PHY_WAIT;
          w_ctr_clr    = 1'b1;
        end else begin
          w_ctr_inc = 1'b1;
        end
      end

      ST_PHY_WAIT: begin
        if (!pll_locked) begin
          w_next_state = ST_WAIT_LOCK;
          w_ctr_clr    = 1'b1;
        end else if (soft_rst) begin
          w_next_state = ST_PHY_RST;
          w_ctr_clr    = 1'b1;
        end else if (r_ctr == c_PHY_WAIT_LAST) begin
          w_next_state = ST_MAC_WAIT;
          w_ctr_clr    = 1'b1;
        end else begin
          w_ctr_inc = 1'b1;
        end
      end

      ST_MAC_WAIT: begin
        if (!pll_locked) begin
          w_next_state = ST_WAIT_LOCK;
          w_ctr_clr    = 1'b1;
        end else if (soft_rst) begin
          w_next_state = ST_PHY_RST;
          w_ctr_clr    = 1'b1;
        end else if (r_ctr == c_MAC_WAIT_LAST) begin
          w_next_state = ST_RUN;
          w_ctr_clr    = 1'b1;
        end else begin
          w_ctr_inc = 1'b1;
        end
      end

      ST_RUN: begin
        // Nothing is timed here, so the counter simply holds.
        if (!pll_locked) begin
          w_next_state = ST_WAIT_LOCK;
          w_ctr_clr    = 1'b1;
        end else if (soft_rst) begin
          w_next_state = ST_PHY_RST;
          w_ctr_clr    = 1'b1;
        end
      end

      default: begin
        // Encodings 5-7 are unreachable; recover through the full sequence.
        w_next_state = ST_WAIT_LOCK;
        w_ctr_clr    = 1'b1;
      end
    endcase
  end

  // Shared counter: cleared on every state change, saturating otherwise.
  always_comb begin
    w_ctr_next = r_ctr;
    if (w_ctr_clr) begin
      w_ctr_next = '0;
    end else if (w_ctr_inc && (r_ctr != c_CTR_MAX)) begin
      w_ctr_next = r_ctr + c_CTR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Each step releases exactly one more reset, which keeps the
  // PHY -> MAC -> application release order intact on every path.
  // --------------------------------------------------------------------------
  always_comb begin
    w_phy_rst_n_next  = 1'b0;
    w_mac_sreset_next = 1'b1;
    w_app_sreset_next = 1'b1;
    w_ready_next      = 1'b0;

    case (w_next_state)
      ST_PHY_WAIT: begin
        w_phy_rst_n_next  = 1'b1;
      end
      ST_MAC_WAIT: begin
        w_phy_rst_n_next  = 1'b1;
        w_mac_sreset_next = 1'b0;
      end
      ST_RUN: begin
        w_phy_rst_n_next  = 1'b1;
        w_mac_sreset_next = 1'b0;
        w_app_sreset_next = 1'b0;
        w_ready_next      = 1'b1;
      end
      default: begin
        // WAIT_LOCK, PHY_RST and the unused encodings hold every reset.
        w_phy_rst_n_next  = 1'b0;
      end
    endcase
  end

  assign phy_rst_n  = r_phy_rst_n;
  assign mac_sreset = r_mac_sreset;
  assign app_sreset = r_app_sreset;
  assign ready      = r_ready;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Self-checking bench for reset_sequencer. A timeline model (lock
//            run length plus elapsed time since the sequence started) predicts
//            the state every cycle; directed scenarios pin key edges with
//            hand-computed literals, then a randomized run follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  localparam int LC = 4;   // lock filter length
  localparam int PR = 8;   // PHY reset pulse length
  localparam int PW = 16;  // PHY settle time
  localparam int MW = 4;   // MAC-to-application gap

  logic       clk        = 1'b0;
  logic       sreset     = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_rst   = 1'b0;
  logic       phy_rst_n;
  logic       mac_sreset;
  logic       app_sreset;
  logic       ready;
  logic [2:0] state;

  always #5 clk = ~clk;

  reset_sequencer #(
    .LOCK_CYCLES    (LC),
    .PHY_RST_CYCLES (PR),
    .PHY_WAIT_CYCLES(PW),
    .MAC_WAIT_CYCLES(MW)
  ) dut (
    .clk       (clk),
    .sreset    (sreset),
    .pll_locked(pll_locked),
    .soft_rst  (soft_rst),
    .phy_rst_n (phy_rst_n),
    .mac_sreset(mac_sreset),
    .app_sreset(app_sreset),
    .ready     (ready),
    .state     (state)
  );

  int checks   = 0;
  int failures = 0;
  int edge_idx = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (edge %0d, t=%0t)",
               name, act, exp, edge_idx, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Timeline model: either filtering lock (counting consecutive locked edges)
  // or sequencing, where the state follows from elapsed time since entry.
  // --------------------------------------------------------------------------
  bit model_valid = 1'b0;
  bit m_in_seq    = 1'b0;
  int m_lock_run  = 0;
  int m_seq_t     = 0;

  always @(posedge clk) begin
    if (sreset) begin
      model_valid = 1'b1;
      m_in_seq    = 1'b0;
      m_lock_run  = 0;
      m_seq_t     = 0;
    end else if (m_in_seq) begin
      if (!pll_locked) begin
        m_in_seq   = 1'b0;
        m_lock_run = 0;
      end else if (soft_rst) begin
        m_seq_t = 0;
      end else if (m_seq_t < PR + PW + MW) begin
        m_seq_t++;
      end
    end else begin
      if (pll_locked) begin
        m_lock_run++;
        if (m_lock_run == LC) begin
          m_in_seq   = 1'b1;
          m_seq_t    = 0;
          m_lock_run = 0;
        end
      end else begin
        m_lock_run = 0;
      end
    end
  end

  function automatic int exp_state();
    if (!m_in_seq)               return 0;
    if (m_seq_t < PR)            return 1;
    if (m_seq_t < PR + PW)       return 2;
    if (m_seq_t < PR + PW + MW)  return 3;
    return 4;
  endfunction

  // Per-cycle comparison against the model plus the ordering invariant.
  always @(negedge clk) begin
    if (model_valid) begin
      int es;
      es = exp_state();
      check("state",      int'(state),      es);
      check("phy_rst_n",  int'(phy_rst_n),  int'(es >= 2));
      check("mac_sreset", int'(mac_sreset), int'(es < 3));
      check("app_sreset", int'(app_sreset), int'(es < 4));
      check("ready",      int'(ready),      int'(es == 4));
      check("order_app_mac", int'(!app_sreset && mac_sreset), 0);
      check("order_mac_phy", int'(!mac_sreset && !phy_rst_n), 0);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. After tick() the bench sits at the falling edge that
  // follows posedge number edge_idx (cycle 0 = first edge with sreset=0).
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    edge_idx++;
    @(negedge clk);
  endtask

  task automatic start();
    sreset     = 1'b1;
    soft_rst   = 1'b0;
    pll_locked = 1'b1;
    tick();
    tick();
    sreset   = 1'b0;
    edge_idx = -1;
  endtask

  task automatic run_to(input int n);
    while (edge_idx < n) tick();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_state"}, int'(state),      0);
    check({tag, "_phy"},   int'(phy_rst_n),  0);
    check({tag, "_mac"},   int'(mac_sreset), 1);
    check({tag, "_app"},   int'(app_sreset), 1);
    check({tag, "_ready"}, int'(ready),      0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);

    // 1. Nominal sequence.
    start();
    check_reset_outs("s1_reset");
    run_to(10); check("s1_phy_e10",   int'(phy_rst_n), 0);
    run_to(11); check("s1_phy_e11",   int'(phy_rst_n), 1);
                check("s1_state_e11", int'(state), 2);
    run_to(26); check("s1_mac_e26",   int'(mac_sreset), 1);
    run_to(27); check("s1_mac_e27",   int'(mac_sreset), 0);
    run_to(30); check("s1_ready_e30", int'(ready), 0);
    run_to(31); check("s1_ready_e31", int'(ready), 1);
                check("s1_app_e31",   int'(app_sreset), 0);
                check("s1_state_e31", int'(state), 4);

    // 2. One-cycle lock glitch inside the filter.
    start();
    run_to(1);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    run_to(33); check("s2_ready_e33", int'(ready), 0);
    run_to(34); check("s2_ready_e34", int'(ready), 1);

    // 3. Lock loss in RUN, then recovery.
    start();
    run_to(39);
    pll_locked = 1'b0;
    tick();
    check_reset_outs("s3_loss");
    pll_locked = 1'b1;
    run_to(71); check("s3_ready_e71", int'(ready), 0);
    run_to(72); check("s3_ready_e72", int'(ready), 1);

    // 4. Soft reset in RUN.
    start();
    run_to(39);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check("s4_state", int'(state), 1);
    check("s4_phy",   int'(phy_rst_n), 0);
    check("s4_ready", int'(ready), 0);
    run_to(67); check("s4_ready_e67", int'(ready), 0);
    run_to(68); check("s4_ready_e68", int'(ready), 1);

    // 5. Soft reset and lock loss together in PHY_WAIT; soft reset in WAIT_LOCK.
    start();
    run_to(14);
    soft_rst   = 1'b1;
    pll_locked = 1'b0;
    tick();
    check("s5_both_state", int'(state), 0);
    tick();
    check("s5_wl_unlocked", int'(state), 0);
    pll_locked = 1'b1;
    tick();
    check("s5_wl_soft", int'(state), 0);
    soft_rst = 1'b0;
    run_to(19); check("s5_state_e19", int'(state), 0);
    run_to(20); check("s5_state_e20", int'(state), 1);

    // 6. sreset mid-MAC_WAIT.
    start();
    run_to(28);
    check("s6_in_mac_wait", int'(state), 3);
    sreset = 1'b1;
    tick();
    check_reset_outs("s6_sreset");
    sreset   = 1'b0;
    edge_idx = -1;
    run_to(2); check("s6_state_e2", int'(state), 0);
    run_to(3); check("s6_state_e3", int'(state), 1);

    // 7. Randomized run; the per-cycle compare does the checking.
    start();
    for (int i = 0; i < 3000; i++) begin
      pll_locked = ($urandom_range(0, 99) >= 3);
      soft_rst   = ($urandom_range(0, 99) < 2);
      sreset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    sreset   = 1'b0;
    soft_rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
